// File: rtl/tile_matcher.sv
// tile_matcher: game logic for a 16-tile memory board (8 pairs, 3-bit symbols).
// Latches the generated map, takes two picks per turn, compares the symbols and
// drives the revealed/matched masks plus match/miss/win events.
// Valid/ready: a pick is taken on any clock edge where pickValid = 1 and the
// block is in FIRST or SECOND; picks at other times or on an illegal tile
// (already matched, or the same as the first pick) are dropped silently.
// Optional macro TILE_MATCHER_MOVES_EN adds a saturating moveCount output.
module tile_matcher #(
   parameter int HOLD_CYCLES = 50_000_000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        finishedGen,
   input  logic [47:0] logicMap,
   input  logic        pickValid,
   input  logic [3:0]  pickIdx,
   output logic [15:0] revealed,
   output logic [15:0] matched,
   output logic [3:0]  pairsLeft,
   output logic        matchPulse,
   output logic        missPulse,
   output logic        gameWon,
   output logic        busy,
`ifdef TILE_MATCHER_MOVES_EN
   output logic [7:0]  moveCount,
`endif
   output logic [2:0]  state_dbg
);

   localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      FIRST   = 3'd1,
      SECOND  = 3'd2,
      COMPARE = 3'd3,
      SHOW    = 3'd4,
      DONE    = 3'd5
   } state_t;

   state_t          state, state_next;
   logic [47:0]     map_q;
   logic [3:0]      idx_a, idx_b;
   logic            cmp_phase;   // COMPARE cycle 0 registers equality, cycle 1 acts on it
   logic            sym_eq;
   logic [CW-1:0]   hold_cnt;
   logic            pick_ok;
   logic            abort;

   function automatic logic [2:0] sym_at(input logic [47:0] m, input logic [3:0] i);
      return m[3*i +: 3];
   endfunction

   assign state_dbg = state;
   assign abort     = (state != IDLE) && !finishedGen;

   // Pick acceptance: only while waiting for a pick, never a matched tile or the first pick again
   always_comb begin
      pick_ok = 1'b0;
      if (pickValid && !matched[pickIdx]) begin
         if (state == FIRST)
            pick_ok = 1'b1;
         else if (state == SECOND && pickIdx != idx_a)
            pick_ok = 1'b1;
      end
   end

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   // Next-state logic; loss of the map overrides everything
   always_comb begin
      state_next = state;
      if (abort) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE:    if (finishedGen) state_next = FIRST;
            FIRST:   if (pick_ok) state_next = SECOND;
            SECOND:  if (pick_ok) state_next = COMPARE;
            COMPARE: if (cmp_phase) begin
                        if (!sym_eq)             state_next = SHOW;
                        else if (pairsLeft == 4'd1) state_next = DONE;
                        else                     state_next = FIRST;
                     end
            SHOW:    if (hold_cnt == '0) state_next = FIRST;
            DONE:    state_next = DONE;
            default: state_next = IDLE;
         endcase
      end
   end

   // Registered datapath and outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         map_q      <= '0;
         idx_a      <= '0;
         idx_b      <= '0;
         cmp_phase  <= 1'b0;
         sym_eq     <= 1'b0;
         hold_cnt   <= '0;
         revealed   <= '0;
         matched    <= '0;
         pairsLeft  <= '0;
         matchPulse <= 1'b0;
         missPulse  <= 1'b0;
         gameWon    <= 1'b0;
         busy       <= 1'b1;
`ifdef TILE_MATCHER_MOVES_EN
         moveCount  <= '0;
`endif
      end else begin
         matchPulse <= 1'b0;
         missPulse  <= 1'b0;
         if (abort || state == IDLE) begin
            cmp_phase <= 1'b0;
            hold_cnt  <= '0;
            revealed  <= '0;
            matched   <= '0;
            pairsLeft <= '0;
            gameWon   <= 1'b0;
            busy      <= 1'b1;
`ifdef TILE_MATCHER_MOVES_EN
            moveCount <= '0;
`endif
            if (!abort && finishedGen) begin
               map_q     <= logicMap;
               pairsLeft <= 4'd8;
               busy      <= 1'b0;
            end
         end else begin
            case (state)
               FIRST: if (pick_ok) begin
                  revealed[pickIdx] <= 1'b1;
                  idx_a             <= pickIdx;
               end
               SECOND: if (pick_ok) begin
                  revealed[pickIdx] <= 1'b1;
                  idx_b             <= pickIdx;
                  busy              <= 1'b1;
                  cmp_phase         <= 1'b0;
               end
               COMPARE: begin
                  if (!cmp_phase) begin
                     sym_eq    <= (sym_at(map_q, idx_a) == sym_at(map_q, idx_b));
                     cmp_phase <= 1'b1;
                  end else begin
                     cmp_phase <= 1'b0;
`ifdef TILE_MATCHER_MOVES_EN
                     if (moveCount != 8'hFF) moveCount <= moveCount + 8'd1;
`endif
                     if (sym_eq) begin
                        matched[idx_a] <= 1'b1;
                        matched[idx_b] <= 1'b1;
                        revealed       <= '0;
                        pairsLeft      <= pairsLeft - 4'd1;
                        matchPulse     <= 1'b1;
                        if (pairsLeft == 4'd1) gameWon <= 1'b1;
                        else                   busy    <= 1'b0;
                     end else begin
                        missPulse <= 1'b1;
                        hold_cnt  <= CW'(HOLD_CYCLES - 1);
                     end
                  end
               end
               SHOW: begin
                  if (hold_cnt == '0) begin
                     revealed <= '0;
                     busy     <= 1'b0;
                  end else begin
                     hold_cnt <= hold_cnt - 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule
